// File: rtl/switch_allocator_rr_if.sv
// Shared NoC constants and the switch-allocator request/grant bundle.
// The input block drives the requests; the allocator returns the grants.
package noc_pkg;
  localparam int NOC_PORTS = 5;
  localparam int VC_NUM    = 4;
  localparam int PORT_W    = $clog2(NOC_PORTS);
  typedef logic [PORT_W-1:0] port_t;
endpackage

interface switch_allocator_rr_if #(
  parameter int PORT_NUM = noc_pkg::NOC_PORTS,
  parameter int VC_NUM   = noc_pkg::VC_NUM
);
  localparam int VW = $clog2(VC_NUM);
  localparam int PW = $clog2(PORT_NUM);

  logic [PORT_NUM-1:0][VC_NUM-1:0]         switch_request_i;
  noc_pkg::port_t [PORT_NUM-1:0][VC_NUM-1:0] out_port_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VW-1:0] downstream_vc_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0]         on_off_i;
  logic [PORT_NUM-1:0]                     valid_sel_o;
  logic [PORT_NUM-1:0][VW-1:0]             vc_sel_o;
  logic [PORT_NUM-1:0]                     xb_valid_o;
  logic [PORT_NUM-1:0][PW-1:0]             xb_sel_o;

  modport master (
    output switch_request_i, out_port_i,
    output downstream_vc_i, on_off_i,
    input  valid_sel_o, vc_sel_o,
    input  xb_valid_o, xb_sel_o
  );

  modport slave (
    input  switch_request_i, out_port_i,
    input  downstream_vc_i, on_off_i,
    output valid_sel_o, vc_sel_o,
    output xb_valid_o, xb_sel_o
  );
endinterface

// File: rtl/switch_allocator_rr.sv
// Separable input-first switch allocator, round-robin at both stages.
// Grants are registered; only the round-robin pointers carry state.
module switch_allocator_rr #(
  parameter int PORT_NUM = noc_pkg::NOC_PORTS,
  parameter int VC_NUM   = noc_pkg::VC_NUM
) (
  input logic clk,
  input logic rst,
  switch_allocator_rr_if.slave sa
);
  localparam int VW = $clog2(VC_NUM);
  localparam int PW = $clog2(PORT_NUM);

  logic [PORT_NUM-1:0][VW-1:0] r_in_ptr;
  logic [PORT_NUM-1:0][PW-1:0] r_out_ptr;
  logic [PORT_NUM-1:0]         r_valid_sel;
  logic [PORT_NUM-1:0][VW-1:0] r_vc_sel;
  logic [PORT_NUM-1:0]         r_xb_valid;
  logic [PORT_NUM-1:0][PW-1:0] r_xb_sel;

  logic [PORT_NUM-1:0][VC_NUM-1:0] w_elig;
  logic [PORT_NUM-1:0]             w_r1;
  logic [PORT_NUM-1:0][VW-1:0]     w_w1;
  logic [PORT_NUM-1:0][PW-1:0]     w_tgt;
  logic [PORT_NUM-1:0]             w_xv;
  logic [PORT_NUM-1:0][PW-1:0]     w_w2;
  logic [PORT_NUM-1:0]             w_gnt;

  // Out-of-range ports or downstream VCs never match, so they stay ineligible.
  always_comb begin
    w_elig = '0;
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_NUM; v++)
        for (int o = 0; o < PORT_NUM; o++)
          for (int d = 0; d < VC_NUM; d++)
            if (sa.switch_request_i[p][v] &&
                int'(sa.out_port_i[p][v]) == o &&
                int'(sa.downstream_vc_i[p][v]) == d &&
                sa.on_off_i[o][d])
              w_elig[p][v] = 1'b1;
  end

  always_comb begin
    int idx;
    w_r1  = '0;
    w_w1  = '0;
    w_tgt = '0;
    idx   = 0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int k = 0; k < VC_NUM; k++) begin
        idx = int'(r_in_ptr[p]) + k;
        if (idx >= VC_NUM) idx = idx - VC_NUM;
        if (!w_r1[p] && w_elig[p][idx]) begin
          w_r1[p] = 1'b1;
          w_w1[p] = VW'(idx);
        end
      end
      w_tgt[p] = PW'(sa.out_port_i[p][w_w1[p]]);
    end
  end

  always_comb begin
    int idx;
    w_xv = '0;
    w_w2 = '0;
    idx  = 0;
    for (int o = 0; o < PORT_NUM; o++)
      for (int k = 0; k < PORT_NUM; k++) begin
        idx = int'(r_out_ptr[o]) + k;
        if (idx >= PORT_NUM) idx = idx - PORT_NUM;
        if (!w_xv[o] && w_r1[idx] && int'(w_tgt[idx]) == o) begin
          w_xv[o] = 1'b1;
          w_w2[o] = PW'(idx);
        end
      end
  end

  always_comb begin
    w_gnt = '0;
    for (int o = 0; o < PORT_NUM; o++)
      for (int p = 0; p < PORT_NUM; p++)
        if (w_xv[o] && int'(w_w2[o]) == p)
          w_gnt[p] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ptr    <= '0;
      r_out_ptr   <= '0;
      r_valid_sel <= '0;
      r_vc_sel    <= '0;
      r_xb_valid  <= '0;
      r_xb_sel    <= '0;
    end else begin
      r_valid_sel <= w_gnt;
      r_xb_valid  <= w_xv;
      for (int p = 0; p < PORT_NUM; p++) begin
        r_vc_sel[p] <= w_gnt[p] ? w_w1[p] : '0;
        if (w_gnt[p])
          r_in_ptr[p] <= (int'(w_w1[p]) == VC_NUM - 1) ?
                         '0 : w_w1[p] + 1'b1;
      end
      for (int o = 0; o < PORT_NUM; o++) begin
        r_xb_sel[o] <= w_xv[o] ? w_w2[o] : '0;
        if (w_xv[o])
          r_out_ptr[o] <= (int'(w_w2[o]) == PORT_NUM - 1) ?
                          '0 : w_w2[o] + 1'b1;
      end
    end
  end

  assign sa.valid_sel_o = r_valid_sel;
  assign sa.vc_sel_o    = r_vc_sel;
  assign sa.xb_valid_o  = r_xb_valid;
  assign sa.xb_sel_o    = r_xb_sel;
endmodule

// File: tb/tb_switch_allocator_rr.sv
// Directed-vector bench for switch_allocator_rr with a scoreboard
// queue filled by the stimulus and drained by a negedge monitor.
module tb_switch_allocator_rr;
  localparam int NP = 5;
  localparam int NV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  switch_allocator_rr_if #(.PORT_NUM(NP), .VC_NUM(NV)) sif();

  switch_allocator_rr #(.PORT_NUM(NP), .VC_NUM(NV)) dut (
    .clk(clk),
    .rst(rst),
    .sa (sif)
  );

  typedef struct packed {
    logic [4:0]      vs;
    logic [4:0][1:0] vc;
    logic [4:0]      xv;
    logic [4:0][2:0] xs;
  } out_t;

  typedef struct {
    int    due;
    out_t  e;
    string name;
  } sb_t;

  sb_t  q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  out_t e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    out_t a;
    sb_t  s;
    a.vs = sif.valid_sel_o;
    a.vc = sif.vc_sel_o;
    a.xv = sif.xb_valid_o;
    a.xs = sif.xb_sel_o;
    while (q.size() > 0 && q[0].due <= cyc) begin
      s = q.pop_front();
      n_vec++;
      if (s.due != cyc || a !== s.e) begin
        n_bad++;
        $display("FAIL %s: got vs=%b vc=%h xv=%b xs=%h want vs=%b vc=%h xv=%b xs=%h",
                 s.name, a.vs, a.vc, a.xv, a.xs, s.e.vs, s.e.vc, s.e.xv, s.e.xs);
      end
    end
  end

  task automatic clr();
    sif.switch_request_i = '0;
    sif.out_port_i       = '0;
    sif.downstream_vc_i  = '0;
    sif.on_off_i         = '1;
  endtask

  task automatic rq(int p, int v, int o, int d);
    sif.switch_request_i[p][v] = 1'b1;
    sif.out_port_i[p][v]       = 3'(o);
    sif.downstream_vc_i[p][v]  = 2'(d);
  endtask

  function automatic void g(int p, int v, int o);
    e.vs[p] = 1'b1;
    e.vc[p] = 2'(v);
    e.xv[o] = 1'b1;
    e.xs[o] = 3'(p);
  endfunction

  task automatic step(string n);
    sb_t s;
    s.due  = cyc + 1;
    s.e    = e;
    s.name = n;
    q.push_back(s);
    e = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    e   = '0;
    clr();
    @(posedge clk);
    #1;
    rq(1, 2, 3, 0);
    step("rst_hold0");
    step("rst_hold1");

    rst = 1'b0;
    g(1, 2, 3);
    step("single");
    clr();
    step("idle0");

    rq(0, 0, 1, 0);
    rq(2, 0, 1, 0);
    rq(4, 0, 1, 0);
    g(0, 0, 1); step("cont_in0");
    g(2, 0, 1); step("cont_in2");
    g(4, 0, 1); step("cont_in4");
    g(0, 0, 1); step("cont_in0_wrap");
    rst = 1'b1;
    step("rst_mid");
    rst = 1'b0;
    g(0, 0, 1); step("post_rst_in0");
    g(2, 0, 1); step("post_rst_in2");
    clr();
    step("idle1");

    rq(3, 0, 0, 1);
    rq(3, 1, 2, 2);
    g(3, 0, 0); step("fair_vc0");
    g(3, 1, 2); step("fair_vc1");
    g(3, 0, 0); step("fair_vc0b");
    g(3, 1, 2); step("fair_vc1b");
    clr();

    rq(2, 0, 4, 3);
    rq(2, 1, 4, 3);
    sif.on_off_i[4][3] = 1'b0;
    for (int i = 0; i < 5; i++) step("blocked");
    sif.on_off_i[4][3] = 1'b1;
    g(2, 1, 4); step("unblock_vc1");
    g(2, 0, 4); step("unblock_vc0_wrap");
    clr();

    for (int p = 0; p < NP; p++) begin
      rq(p, p % NV, (p + 1) % NP, p % NV);
      g(p, p % NV, (p + 1) % NP);
    end
    step("full_parallel");
    clr();

    rq(0, 0, 6, 0);
    rq(1, 0, 5, 0);
    step("bad_port");
    clr();
    step("idle2");

    @(posedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/switch_allocator_rr.md
# switch_allocator_rr

Separable input-first switch allocator that shares the crossbar among the router's input ports. Each cycle it picks at most one requesting VC per input port, then at most one input port per output port, both with round-robin fairness. Grants go back to the input ports (which VC may dequeue) and to the crossbar (which input drives each output). It sits beside the input block and VC allocator inside the router and is the only sequencer of crossbar traversal.

## Interface
Parameters:
- PORT_NUM, 5, number of input ports and of output ports.
- VC_NUM, noc_pkg VC_NUM, virtual channels per port.

Ports:
- clk  input  1  router clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- switch_request_i  input  [PORT_NUM][VC_NUM]  VC v of input p holds a flit with an allocated downstream VC.
- out_port_i  input  port_t [PORT_NUM][VC_NUM]  output port of the head flit of each VC; port_t value is the output index.
- downstream_vc_i  input  [PORT_NUM][VC_NUM] x clog2(VC_NUM)  downstream VC allocated to each VC.
- on_off_i  input  [PORT_NUM][VC_NUM]  on/off flow control from downstream, indexed [output port][downstream VC]; 1 = may accept a flit.
- valid_sel_o  output  [PORT_NUM]  input p granted this cycle.
- vc_sel_o  output  [PORT_NUM] x clog2(VC_NUM)  granted VC of input p; meaningful only with valid_sel_o[p].
- xb_valid_o  output  [PORT_NUM]  output o carries a flit this cycle.
- xb_sel_o  output  [PORT_NUM] x clog2(PORT_NUM)  input port driving output o; meaningful only with xb_valid_o[o].

## Operation
- Eligibility: VC v of input p is eligible iff switch_request_i[p][v] and on_off_i[out_port_i[p][v]][downstream_vc_i[p][v]]. out_port_i values >= PORT_NUM make the VC ineligible.
- Stage 1 (per input p): round-robin over eligible VCs starting at in_ptr[p]; winner w1[p]; request r1[p] = any eligible.
- Stage 2 (per output o): candidates = inputs p with r1[p] and out_port_i[p][w1[p]] == o; round-robin starting at out_ptr[o]; winner w2[o].
- Input p is granted iff it is stage-2 winner of its target output. Each input gets at most one grant; each output at most one input.
- Pointer update (only on a grant, same edge as outputs register):
  - in_ptr[p] <= (w1[p] + 1) mod VC_NUM when input p granted; unchanged if its stage-1 winner lost stage 2.
  - out_ptr[o] <= (w2[o] + 1) mod PORT_NUM when output o granted; unchanged otherwise.
- Wrap-around: pointer arithmetic modulo VC_NUM / PORT_NUM; clog2 widths, no extra bit; non-power-of-two sizes wrap explicitly.
- No request, or all VCs blocked by on_off: no grant, pointers hold.
- Allocator is stateless besides pointers; a request still asserted after a grant is re-arbitrated as new.

## Timing
- Allocation combinational from inputs sampled at edge N; valid_sel_o, vc_sel_o, xb_valid_o, xb_sel_o registered, visible after edge N (one-cycle latency), held one cycle only.
- Input port must deassert switch_request_i for a VC in the cycle its grant is visible unless it has another flit; a request held through the grant cycle may win again.
- on_off_i sampled in the same cycle as the request; a downstream VC going off blocks allocation from that cycle.
- Reset: with rst high at an edge, all outputs go 0, in_ptr and out_ptr go 0, regardless of requests; first grant possible at the edge after rst deasserts. Reset mid-operation drops any pending grant.
- Simultaneous grant and reset: reset wins.

## Test plan
- Single request: input 1 VC 2 to output 3, on_off on -> next cycle valid_sel_o[1]=1, vc_sel_o[1]=2, xb_valid_o[3]=1, xb_sel_o[3]=1; all else 0.
- Output contention: inputs 0, 2, 4 all request output 1 continuously -> grants to 0, 2, 4, 0 on consecutive cycles; one xb_valid_o bit per cycle.
- VC fairness: input 3 VCs 0 and 1 both request distinct free outputs -> VC 0 then VC 1 alternate; never two grants to input 3 in one cycle.
- Flow control: only request targets downstream VC with on_off_i=0 -> no grant for 5 cycles, pointers unchanged; raise on_off -> grant the following cycle.
- Full parallelism: 5 inputs request 5 distinct outputs -> all valid_sel_o and xb_valid_o bits set in one cycle with matching xb_sel_o.
- Reset mid-run: assert rst during contention test -> outputs 0 next cycle; after release first grant goes to input 0 (pointers reset).
